// File: rtl/ltc_pkg.sv
// Shared definitions for the multi-approach traffic-light controller.
//   ltc_state_t : controller phase encoding
//   MAX_DIR     : largest supported number of vehicle approaches
//   ALL_RED     : lamp vector with every approach lit, sliced to NUM_DIR by users
package ltc_pkg;

    typedef enum logic [2:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_PED,
        ST_FLASH
    } ltc_state_t;

    localparam int unsigned MAX_DIR = 4;
    localparam logic [MAX_DIR-1:0] ALL_RED = '1;

endpackage

// File: rtl/ltc_timer.sv
// Loadable down-counter used for phase and flash timing.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset, counter returns to RST_VAL
//   load     : load load_val this cycle (overrides counting)
//   load_val : value loaded into the counter
//   zero     : counter currently reads zero; counting stops there
module ltc_timer
    import ltc_pkg::*;
#(
    parameter int              CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ltc_multi.sv
// Multi-approach traffic-light controller: round-robin greens over NUM_DIR
// approaches, all-red clearance between every green, an exclusive pedestrian
// walk phase on request, and a night mode flashing all approaches yellow.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   ped_req  : pedestrian request level, sampled every cycle
//   night    : night-mode request level, acted on at all-red exit
//   red/yel/grn : per-approach lamps (registered)
//   ped_walk : walk lamp, high only during the pedestrian phase
//   ped_wait : a pedestrian request is latched and not yet served
//
// state     | meaning
// ST_GREEN  | grn[dir] lit, other approaches red
// ST_YELLOW | yel[dir] lit, other approaches red
// ST_ALLRED | clearance, every approach red
// ST_PED    | every approach red, walk lamp lit
// ST_FLASH  | night mode, all yellow blinking, nothing else lit
module ltc_multi
    import ltc_pkg::*;
#(
    parameter int NUM_DIR  = 2,
    parameter int CNT_W    = 8,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 1,
    parameter int PED_T    = 6,
    parameter int FLASH_T  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ped_req,
    input  logic               night,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yel,
    output logic [NUM_DIR-1:0] grn,
    output logic               ped_walk,
    output logic               ped_wait
);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
    localparam logic [1:0]       DIR_LAST  = 2'(NUM_DIR - 1);

    ltc_state_t state, state_nxt;
    logic [1:0] dir, dir_nxt;
    logic       ped_pending, pend_nxt;
    logic       ped_done, done_nxt;
    logic       flash_ph, flash_ph_nxt;

    logic             ph_load, ph_zero, fl_load, fl_zero;
    logic [CNT_W-1:0] ph_val;

    logic [NUM_DIR-1:0] red_nxt, yel_nxt, grn_nxt;
    logic               walk_nxt;

    ltc_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_LD)) u_phase_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    ltc_timer #(.CNT_W(CNT_W), .RST_VAL('0)) u_flash_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (fl_load),
        .load_val (FLASH_LD),
        .zero     (fl_zero)
    );

    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir;
        done_nxt     = ped_done;
        flash_ph_nxt = flash_ph;
        pend_nxt     = ped_pending;
        ph_load      = 1'b0;
        ph_val       = '0;
        fl_load      = 1'b0;

        case (state)
            ST_GREEN: if (ph_zero) begin
                state_nxt = ST_YELLOW;
                ph_load   = 1'b1;
                ph_val    = YELLOW_LD;
            end
            ST_YELLOW: if (ph_zero) begin
                state_nxt = ST_ALLRED;
                ph_load   = 1'b1;
                ph_val    = ALLRED_LD;
            end
            ST_ALLRED: if (ph_zero) begin
                if (night) begin
                    state_nxt    = ST_FLASH;
                    fl_load      = 1'b1;
                    flash_ph_nxt = 1'b1;
                end else if (ped_pending && !ped_done) begin
                    state_nxt = ST_PED;
                    ph_load   = 1'b1;
                    ph_val    = PED_LD;
                end else begin
                    state_nxt = ST_GREEN;
                    dir_nxt   = (dir == DIR_LAST) ? 2'd0 : dir + 2'd1;
                    done_nxt  = 1'b0;
                    ph_load   = 1'b1;
                    ph_val    = GREEN_LD;
                end
            end
            ST_PED: if (ph_zero) begin
                state_nxt = ST_ALLRED;
                done_nxt  = 1'b1;
                ph_load   = 1'b1;
                ph_val    = ALLRED_LD;
            end
            ST_FLASH: if (fl_zero) begin
                flash_ph_nxt = ~flash_ph;
                fl_load      = 1'b1;
                if (!night) begin
                    // Park on the last approach so the rotation resumes at 0.
                    state_nxt = ST_ALLRED;
                    dir_nxt   = DIR_LAST;
                    done_nxt  = 1'b0;
                    ph_load   = 1'b1;
                    ph_val    = ALLRED_LD;
                end
            end
            default: begin
                state_nxt = ST_ALLRED;
                ph_load   = 1'b1;
                ph_val    = ALLRED_LD;
            end
        endcase

        // Requests are not latched while walking or flashing; entering either
        // of those phases also discards whatever was pending.
        if (state == ST_FLASH || state_nxt == ST_FLASH ||
            state == ST_PED   || state_nxt == ST_PED) begin
            pend_nxt = 1'b0;
        end else if (ped_req) begin
            pend_nxt = 1'b1;
        end
    end

    // Lamps are decoded from the next state so the registered outputs line
    // up with the registered state.
    always_comb begin
        red_nxt  = ALL_RED[NUM_DIR-1:0];
        yel_nxt  = '0;
        grn_nxt  = '0;
        walk_nxt = 1'b0;
        case (state_nxt)
            ST_GREEN, ST_YELLOW: begin
                for (int i = 0; i < NUM_DIR; i++) begin
                    if (dir_nxt == 2'(i)) begin
                        red_nxt[i] = 1'b0;
                        if (state_nxt == ST_GREEN) grn_nxt[i] = 1'b1;
                        else                       yel_nxt[i] = 1'b1;
                    end
                end
            end
            ST_PED:   walk_nxt = 1'b1;
            ST_FLASH: begin
                red_nxt = '0;
                yel_nxt = {NUM_DIR{flash_ph_nxt}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_ALLRED;
            dir         <= DIR_LAST;
            ped_pending <= 1'b0;
            ped_done    <= 1'b0;
            flash_ph    <= 1'b0;
            red         <= ALL_RED[NUM_DIR-1:0];
            yel         <= '0;
            grn         <= '0;
            ped_walk    <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir         <= dir_nxt;
            ped_pending <= pend_nxt;
            ped_done    <= done_nxt;
            flash_ph    <= flash_ph_nxt;
            red         <= red_nxt;
            yel         <= yel_nxt;
            grn         <= grn_nxt;
            ped_walk    <= walk_nxt;
        end
    end

    assign ped_wait = ped_pending;

endmodule

// File: tb/tb_ltc_multi.sv
// Testbench for ltc_multi. Two instances: the default two-approach build and
// a four-approach build with single-cycle phases. Both are compared each
// cycle against a phase/age reference model kept here.
module tb_ltc_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       ped_req, night, ped4, night4;
    logic [1:0] red, yel, grn;
    logic       ped_walk, ped_wait;
    logic [3:0] red4, yel4, grn4;
    logic       walk4, wait4;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    ltc_multi u_dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .night(night),
        .red(red), .yel(yel), .grn(grn), .ped_walk(ped_walk), .ped_wait(ped_wait)
    );

    ltc_multi #(.NUM_DIR(4), .GREEN_T(1), .YELLOW_T(1), .ALLRED_T(1),
                .PED_T(2), .FLASH_T(1)) u_dut4 (
        .clk(clk), .rst(rst), .ped_req(ped4), .night(night4),
        .red(red4), .yel(yel4), .grn(grn4), .ped_walk(walk4), .ped_wait(wait4)
    );

    localparam int P_GRN = 0, P_YEL = 1, P_AR = 2, P_PED = 3, P_FL = 4;

    typedef struct {
        int ph;
        int dir;
        int age;   // cycles already spent in the current phase
        bit pend;
        bit done;
        bit fph;
        int fage;  // cycles already spent in the current flash half-period
    } mdl_t;

    mdl_t m2, m4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mreset(input int nd);
        mdl_t m;
        m.ph = P_AR; m.dir = nd - 1; m.age = 0;
        m.pend = 0; m.done = 0; m.fph = 0; m.fage = 0;
        return m;
    endfunction

    function automatic int dur(input int ph, input int gt, input int yt,
                               input int at, input int pt);
        case (ph)
            P_GRN:   return gt;
            P_YEL:   return yt;
            P_PED:   return pt;
            default: return at;
        endcase
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int nd, input int gt,
                                   input int yt, input int at, input int pt,
                                   input int ft, input bit preq, input bit nt);
        mdl_t n;
        n = m;
        if (m.ph == P_FL) begin
            if (m.fage + 1 == ft) begin
                n.fph  = !m.fph;
                n.fage = 0;
                if (!nt) begin
                    n.ph = P_AR; n.age = 0; n.dir = nd - 1; n.done = 0;
                end
            end else begin
                n.fage = m.fage + 1;
            end
        end else if (m.age + 1 == dur(m.ph, gt, yt, at, pt)) begin
            n.age = 0;
            case (m.ph)
                P_GRN: n.ph = P_YEL;
                P_YEL: n.ph = P_AR;
                P_PED: begin n.ph = P_AR; n.done = 1; end
                default: begin
                    if (nt) begin
                        n.ph = P_FL; n.fph = 1; n.fage = 0;
                    end else if (m.pend && !m.done) begin
                        n.ph = P_PED;
                    end else begin
                        n.ph = P_GRN; n.dir = (m.dir + 1) % nd; n.done = 0;
                    end
                end
            endcase
        end else begin
            n.age = m.age + 1;
        end
        if (m.ph == P_FL || n.ph == P_FL || m.ph == P_PED || n.ph == P_PED)
            n.pend = 0;
        else if (preq)
            n.pend = 1;
        return n;
    endfunction

    task automatic mcheck(input string nm, input mdl_t m, input int nd,
                          input logic [3:0] r, input logic [3:0] y,
                          input logic [3:0] g, input logic w, input logic pw);
        logic [3:0] mask, er, ey, eg;
        mask = 4'((1 << nd) - 1);
        er = mask; ey = '0; eg = '0;
        case (m.ph)
            P_GRN: begin eg = 4'(1 << m.dir); er = mask & ~eg; end
            P_YEL: begin ey = 4'(1 << m.dir); er = mask & ~ey; end
            P_FL:  begin er = '0; ey = m.fph ? mask : 4'h0; end
            default: ;
        endcase
        chk({nm, ".red"},  32'(r),  32'(er));
        chk({nm, ".yel"},  32'(y),  32'(ey));
        chk({nm, ".grn"},  32'(g),  32'(eg));
        chk({nm, ".walk"}, 32'(w),  32'(m.ph == P_PED));
        chk({nm, ".wait"}, 32'(pw), 32'(m.pend));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m2 = mstep(m2, 2, 8, 3, 1, 6, 4, ped_req, night);
            m4 = mstep(m4, 4, 1, 1, 1, 2, 1, ped4, night4);
        end
        @(negedge clk);
        mcheck("d2", m2, 2, {2'b00, red}, {2'b00, yel}, {2'b00, grn}, ped_walk, ped_wait);
        mcheck("d4", m4, 4, red4, yel4, grn4, walk4, wait4);
        chk("d4.grn_onehot", 32'($countones(grn4) <= 1), 32'd1);
        ped4 = ($urandom_range(3) == 0);
        if ($urandom_range(29) == 0) night4 = !night4;
    endtask

    initial begin
        int k;
        rst = 1'b0; ped_req = 1'b0; night = 1'b0; ped4 = 1'b0; night4 = 1'b0;
        m2 = mreset(2);
        m4 = mreset(4);
        #1;
        repeat (3) cycle();
        rst = 1'b1;

        // Quiet rotation: first green, phase lengths, period.
        repeat (40) cycle();

        // Single pedestrian pulse during grn[0].
        k = 0;
        while (!grn[0] && k < 60) begin cycle(); k++; end
        chk("wait_grn0", 32'(grn[0]), 32'd1);
        ped_req = 1'b1; cycle(); ped_req = 1'b0;
        repeat (40) cycle();

        // Request held through the walk phase.
        ped_req = 1'b1;
        k = 0;
        while (!ped_walk && k < 80) begin cycle(); k++; end
        chk("wait_walk", 32'(ped_walk), 32'd1);
        repeat (12) cycle();
        ped_req = 1'b0;
        repeat (60) cycle();

        // Night requested mid-green, then released.
        k = 0;
        while (grn == 2'b00 && k < 60) begin cycle(); k++; end
        chk("wait_grn", 32'(grn != 2'b00), 32'd1);
        repeat (2) cycle();
        night = 1'b1;
        repeat (40) cycle();
        night = 1'b0;
        repeat (40) cycle();

        // Asynchronous reset in the middle of yellow.
        k = 0;
        while (yel == 2'b00 && k < 60) begin cycle(); k++; end
        chk("wait_yel", 32'(yel != 2'b00), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_red", 32'(red), 32'h3);
        chk("rst_yel", 32'(yel), 32'h0);
        chk("rst_grn", 32'(grn), 32'h0);
        chk("rst_walk", 32'(ped_walk), 32'h0);
        m2 = mreset(2);
        m4 = mreset(4);
        repeat (2) cycle();
        rst = 1'b1;
        repeat (30) cycle();

        // Random traffic on both instances.
        repeat (3000) begin
            ped_req = ($urandom_range(7) == 0);
            if ($urandom_range(59) == 0) night = !night;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
